// File: rtl/keypad_scan_controller_if.sv
// Key FIFO consumer handshake between the keypad scan controller and the display/consumer logic.
interface keypad_scan_controller_if;
  logic [3:0] key_code;
  logic       key_avail;
  logic       key_pop;
  logic       ovf_clr;
  logic       overflow;

  modport master (output key_code, output key_avail, output overflow,
                  input  key_pop,  input  ovf_clr);
  modport slave  (input  key_code, input  key_avail, input  overflow,
                  output key_pop,  output ovf_clr);
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scan sequencer with a small key-code FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_TYPEMATIC_EN.
module keypad_scan_controller #(
`ifdef KEYPAD_TYPEMATIC_EN
  parameter int REPEAT_DLY  = 5000000,
  parameter int REPEAT_PER  = 1000000,
`endif
  parameter int SCAN_DIV    = 10000,
  parameter int SETTLE_CYC  = 16,
  parameter int RELEASE_CYC = 100000,
  parameter int DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            row_hit,
  input  logic                            enc_a,
  input  logic                            enc_b,
  output logic [1:0]                      col_sel,
  output logic                            key_held,
  keypad_scan_controller_if.master        kbus
);

  localparam int CNT_MAX = (SCAN_DIV > RELEASE_CYC) ? SCAN_DIV : RELEASE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FCNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         col_q, col_d;
  logic               key_held_q, key_held_d;
  logic [3:0]         mem_q [DEPTH];
  logic [3:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [3:0]         head_q, head_d;
  logic               avail_q, avail_d;
  logic               ovf_q, ovf_d;

  logic               cap_push_s, push_s, pop_s, wr_s, full_s;
  logic [3:0]         cap_code_s, push_data_s;

  assign cap_code_s = {col_q, enc_a, enc_b};

  // Scan/confirm/capture/hold sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    cap_push_s = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (row_hit && (cnt_q >= CNT_W'(SETTLE_CYC - 1))) begin
          state_d = ST_CONFIRM;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          col_d = col_q + 2'd1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (!row_hit) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        cap_push_s = 1'b1;
        state_d    = ST_HOLD;
        cnt_d      = '0;
      end
      ST_HOLD: begin
        if (row_hit) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(RELEASE_CYC - 1)) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
        col_d   = 2'd0;
      end
    endcase
    key_held_d = (state_d == ST_HOLD);
  end

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_arm_q, rpt_arm_d;
  logic [3:0]       last_code_q, last_code_d;
  logic             rpt_push_s;
  logic [RPT_W-1:0] rpt_lim_s;

  // Auto-repeat timer: first push after REPEAT_DLY, then every REPEAT_PER
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_arm_d   = 1'b0;
    rpt_push_s  = 1'b0;
    rpt_lim_s   = rpt_arm_q ? RPT_W'(REPEAT_PER - 1) : RPT_W'(REPEAT_DLY - 1);
    last_code_d = cap_push_s ? cap_code_s : last_code_q;
    if ((state_q == ST_HOLD) && row_hit) begin
      if (rpt_cnt_q == rpt_lim_s) begin
        rpt_push_s = 1'b1;
        rpt_arm_d  = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        rpt_arm_d = rpt_arm_q;
      end
    end else begin
      rpt_cnt_d = '0;
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_arm_q   <= 1'b0;
      last_code_q <= 4'd0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_arm_q   <= rpt_arm_d;
      last_code_q <= last_code_d;
    end
  end

  assign push_s      = cap_push_s | rpt_push_s;
  assign push_data_s = cap_push_s ? cap_code_s : last_code_q;
`else
  assign push_s      = cap_push_s;
  assign push_data_s = cap_code_s;
`endif

  // FIFO bookkeeping with a registered head so key_code never depends on a read mux
  always_comb begin
    full_s   = (fcnt_q == FCNT_W'(DEPTH));
    pop_s    = kbus.key_pop && (fcnt_q != '0);
    wr_s     = push_s && (!full_s || pop_s);
    mem_d    = mem_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = push_data_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    fcnt_d   = fcnt_q + FCNT_W'(wr_s) - FCNT_W'(pop_s);
    if (pop_s && (fcnt_q == FCNT_W'(1))) begin
      head_d = wr_s ? push_data_s : head_q;
    end else if (pop_s) begin
      head_d = mem_q[rd_ptr_d];
    end else if (wr_s && (fcnt_q == '0)) begin
      head_d = push_data_s;
    end else begin
      head_d = head_q;
    end
    avail_d = (fcnt_d != '0);
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (kbus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // All sequencer and FIFO state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SCAN;
      cnt_q      <= '0;
      col_q      <= 2'd0;
      key_held_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fcnt_q     <= '0;
      head_q     <= 4'd0;
      avail_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      key_held_q <= key_held_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fcnt_q     <= fcnt_d;
      head_q     <= head_d;
      avail_q    <= avail_d;
      ovf_q      <= ovf_d;
    end
  end

  assign col_sel        = col_q;
  assign key_held       = key_held_q;
  assign kbus.key_code  = head_q;
  assign kbus.key_avail = avail_q;
  assign kbus.overflow  = ovf_q;

endmodule
